song_sequencer: RTL and testbench

- Control block for the music player datapath. It decodes the single-cycle `play_pause` and `next` button pulses into the global `play` state and the current song selection.
- While playing, it walks the song ROM note by note. Each note word is handed to the note player with a one-cycle load pulse; the sequencer then waits for the note player's completion handshake before fetching the next note.
- It sits between the button conditioning logic and the song ROM / note player pair inside the top-level player.

---
 rtl/song_sequencer_if.sv | 29 ++
 rtl/song_sequencer.sv | 96 +++++++++
 tb/tb_song_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/song_sequencer_if.sv
// Bundles the button pulses, song ROM port and note player handshake
// seen by the song sequencer.
interface song_sequencer_if #(
  parameter int NOTE_AW = 5,
  parameter int NOTE_W  = 6,
  parameter int DUR_W   = 6
);
  logic                      play_pause;
  logic                      next;
  logic                      note_done;
  logic [NOTE_W+DUR_W-1:0]   rom_data;
  logic [NOTE_AW+1:0]        rom_addr;
  logic                      play;
  logic [1:0]                song;
  logic [NOTE_W-1:0]         note;
  logic [DUR_W-1:0]          duration;
  logic                      load_new_note;
  logic                      reset_player;

  modport master (
    input  play_pause, next, note_done, rom_data,
    output rom_addr, play, song, note, duration, load_new_note, reset_player
  );

  modport slave (
    output play_pause, next, note_done, rom_data,
    input  rom_addr, play, song, note, duration, load_new_note, reset_player
  );
endinterface

// File: rtl/song_sequencer.sv
// Song sequencer: play/pause and song selection control, and note-by-note
// walk of the song ROM with a load/done handshake to the note player.
module song_sequencer #(
  parameter int NOTE_AW = 5,
  parameter int NOTE_W  = 6,
  parameter int DUR_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  song_sequencer_if.master  bus
);

  localparam logic [2:0] FETCH     = 3'd0;
  localparam logic [2:0] WAIT_ROM  = 3'd1;
  localparam logic [2:0] LOAD      = 3'd2;
  localparam logic [2:0] WAIT_NOTE = 3'd3;
  localparam logic [2:0] SONG_END  = 3'd4;

  logic [2:0]         state;
  logic [NOTE_AW-1:0] note_idx;
  logic [1:0]         song_r;
  logic               play_r;
  logic [NOTE_W-1:0]  note_r;
  logic [DUR_W-1:0]   duration_r;
  logic               load_r;
  logic               reset_player_r;
  logic [NOTE_W-1:0]  rom_note;
  logic [DUR_W-1:0]   rom_dur;

  assign {rom_note, rom_dur} = bus.rom_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= FETCH;
      note_idx       <= '0;
      song_r         <= '0;
      play_r         <= 1'b0;
      note_r         <= '0;
      duration_r     <= '0;
      load_r         <= 1'b0;
      reset_player_r <= 1'b0;
    end else begin
      load_r         <= 1'b0;
      reset_player_r <= 1'b0;
      // A next pulse and the end-of-song state share one song-change action;
      // next outranks play_pause and any pending load.
      if (bus.next || state == SONG_END) begin
        play_r         <= 1'b0;
        song_r         <= song_r + 2'd1;
        note_idx       <= '0;
        reset_player_r <= 1'b1;
        state          <= FETCH;
      end else begin
        if (bus.play_pause)
          play_r <= ~play_r;
        case (state)
          FETCH: begin
            if (play_r)
              state <= WAIT_ROM;
          end
          WAIT_ROM: state <= LOAD;
          LOAD: begin
            if (rom_dur == '0) begin
              state <= SONG_END;
            end else begin
              note_r     <= rom_note;
              duration_r <= rom_dur;
              load_r     <= 1'b1;
              state      <= WAIT_NOTE;
            end
          end
          WAIT_NOTE: begin
            if (bus.note_done) begin
              if (note_idx == '1) begin
                state <= SONG_END;
              end else begin
                note_idx <= note_idx + 1'b1;
                state    <= FETCH;
              end
            end
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

  assign bus.rom_addr      = {song_r, note_idx};
  assign bus.play          = play_r;
  assign bus.song          = song_r;
  assign bus.note          = note_r;
  assign bus.duration      = duration_r;
  assign bus.load_new_note = load_r;
  assign bus.reset_player  = reset_player_r;

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: a synchronous ROM model with random
// songs, and expected note streams derived from the song contents.
module tb_song_sequencer;
  localparam int NOTE_AW = 5;
  localparam int NOTE_W  = 6;
  localparam int DUR_W   = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  song_sequencer_if #(.NOTE_AW(NOTE_AW), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) bus ();

  song_sequencer #(.NOTE_AW(NOTE_AW), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [11:0] mem [128];
  logic [11:0] rom_q;
  always @(posedge clk) rom_q <= mem[bus.rom_addr];
  assign bus.rom_data = rom_q;

  int total = 0;
  int bad   = 0;

  // which: 0 play_pause, 1 next, 2 note_done, 3 next+play_pause together
  task automatic pulse(input int which);
    @(negedge clk);
    case (which)
      0: bus.play_pause = 1'b1;
      1: bus.next = 1'b1;
      2: bus.note_done = 1'b1;
      default: begin bus.next = 1'b1; bus.play_pause = 1'b1; end
    endcase
    @(negedge clk);
    bus.play_pause = 1'b0;
    bus.next       = 1'b0;
    bus.note_done  = 1'b0;
  endtask

  // Steps cycles until the chosen strobe appears; reports the cycle count
  // (-1 on timeout) and whether the other strobe was seen on the way.
  task automatic wait_strobe(input bit want_rp, input int limit, output int cyc, output bit other);
    cyc = -1;
    other = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if ((want_rp ? bus.load_new_note : bus.reset_player) === 1'b1) other = 1'b1;
      if ((want_rp ? bus.reset_player : bus.load_new_note) === 1'b1) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.play_pause = 1'b0;
    bus.next = 1'b0;
    bus.note_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if ({bus.play, bus.song, bus.rom_addr, bus.load_new_note, bus.reset_player} !== '0) begin
        bad++;
        $display("FAIL idle_outputs: play=%0b song=%0d addr=%0h load=%0b rp=%0b required all 0",
                 bus.play, bus.song, bus.rom_addr, bus.load_new_note, bus.reset_player);
      end
    end
    total++;
    if ({bus.note, bus.duration} !== '0) begin
      bad++; $display("FAIL reset_note: got %0h/%0h required 0/0", bus.note, bus.duration);
    end
    pulse(2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (bus.load_new_note !== 1'b0 || bus.rom_addr !== 7'h00) begin
        bad++; $display("FAIL stray_note_done: load=%0b addr=%0h required 0/0", bus.load_new_note, bus.rom_addr);
      end
    end
  endtask

  task automatic play_song(input int s, input int max_delay, input bit pauses);
    int len, cyc, d;
    bit other, full;
    logic [11:0] w;
    logic [6:0] ea, held;
    logic [1:0] es;
    len = 0;
    while (len < 32 && mem[s*32 + len][5:0] != 6'd0) len++;
    full = (len == 32);
    pulse(0);
    total++;
    if (bus.play !== 1'b1) begin bad++; $display("FAIL play_on: got %0b required 1", bus.play); end
    for (int i = 0; i < len; i++) begin
      w = mem[s*32 + i];
      ea = {2'(s), 5'(i)};
      wait_strobe(1'b0, 10, cyc, other);
      total++;
      if (cyc != 3 || other) begin
        bad++; $display("FAIL load_gap: song %0d note %0d got %0d cycles (rp=%0b) required 3", s, i, cyc, other);
      end
      total++;
      if (bus.note !== w[11:6] || bus.duration !== w[5:0] || bus.rom_addr !== ea) begin
        bad++;
        $display("FAIL load_word: got note=%0d dur=%0d addr=%0h required note=%0d dur=%0d addr=%0h",
                 bus.note, bus.duration, bus.rom_addr, w[11:6], w[5:0], ea);
      end
      if (pauses && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 10)) @(negedge clk);
        pulse(0);
        total++;
        if (bus.play !== 1'b0) begin bad++; $display("FAIL pause: got play=%0b required 0", bus.play); end
        held = bus.rom_addr;
        repeat (8) begin
          @(negedge clk);
          total++;
          if (bus.load_new_note !== 1'b0 || bus.rom_addr !== held || bus.play !== 1'b0) begin
            bad++; $display("FAIL paused_idle: load=%0b addr=%0h play=%0b required 0/%0h/0",
                            bus.load_new_note, bus.rom_addr, bus.play, held);
          end
        end
        pulse(0);
        total++;
        if (bus.play !== 1'b1) begin bad++; $display("FAIL resume: got play=%0b required 1", bus.play); end
      end
      d = $urandom_range(1, max_delay);
      repeat (d - 1) @(negedge clk);
      pulse(2);
    end
    es = 2'(s + 1);
    wait_strobe(1'b1, 10, cyc, other);
    total++;
    if (cyc != (full ? 1 : 4) || other) begin
      bad++; $display("FAIL song_end_gap: song %0d got %0d cycles (load=%0b) required %0d", s, cyc, other, full ? 1 : 4);
    end
    total++;
    if (bus.play !== 1'b0 || bus.song !== es || bus.rom_addr !== {es, 5'd0}) begin
      bad++; $display("FAIL song_end_state: play=%0b song=%0d addr=%0h required 0/%0d/%0h",
                      bus.play, bus.song, bus.rom_addr, es, {es, 5'd0});
    end
    @(negedge clk);
    total++;
    if (bus.reset_player !== 1'b0) begin bad++; $display("FAIL rp_width: got rp=%0b required 0", bus.reset_player); end
  endtask

  task automatic test_next_with_play_pause();
    pulse(3);
    total++;
    if (bus.song !== 2'd0 || bus.play !== 1'b0 || bus.reset_player !== 1'b1 ||
        bus.rom_addr !== 7'h00 || bus.load_new_note !== 1'b0) begin
      bad++; $display("FAIL next_wrap: song=%0d play=%0b rp=%0b addr=%0h load=%0b required 0/0/1/0/0",
                      bus.song, bus.play, bus.reset_player, bus.rom_addr, bus.load_new_note);
    end
    @(negedge clk);
    total++;
    if (bus.reset_player !== 1'b0) begin bad++; $display("FAIL next_rp_width: got rp=%0b required 0", bus.reset_player); end
  endtask

  task automatic test_next_during_load();
    pulse(0);
    @(negedge clk);
    @(negedge clk);
    bus.next = 1'b1;
    @(negedge clk);
    bus.next = 1'b0;
    total++;
    if (bus.load_new_note !== 1'b0 || bus.reset_player !== 1'b1 || bus.play !== 1'b0 || bus.song !== 2'd1) begin
      bad++; $display("FAIL next_vs_load: load=%0b rp=%0b play=%0b song=%0d required 0/1/0/1",
                      bus.load_new_note, bus.reset_player, bus.play, bus.song);
    end
    repeat (6) begin
      @(negedge clk);
      total++;
      if (bus.load_new_note !== 1'b0 || bus.reset_player !== 1'b0) begin
        bad++; $display("FAIL after_next_quiet: load=%0b rp=%0b required 0/0", bus.load_new_note, bus.reset_player);
      end
    end
  endtask

  task automatic test_next_mid_note();
    int cyc;
    bit other;
    pulse(0);
    wait_strobe(1'b0, 10, cyc, other);
    total++;
    if (cyc != 3) begin bad++; $display("FAIL mid_note_load: got %0d cycles required 3", cyc); end
    repeat (5) @(negedge clk);
    pulse(1);
    total++;
    if (bus.play !== 1'b0 || bus.song !== 2'd2 || bus.reset_player !== 1'b1 || bus.rom_addr !== 7'h40) begin
      bad++; $display("FAIL next_mid_note: play=%0b song=%0d rp=%0b addr=%0h required 0/2/1/40",
                      bus.play, bus.song, bus.reset_player, bus.rom_addr);
    end
    pulse(2);
    repeat (6) begin
      @(negedge clk);
      total++;
      if (bus.load_new_note !== 1'b0 || bus.rom_addr !== 7'h40) begin
        bad++; $display("FAIL ignored_done: load=%0b addr=%0h required 0/40", bus.load_new_note, bus.rom_addr);
      end
    end
  endtask

  task automatic test_reset_mid_note();
    int cyc;
    bit other;
    pulse(0);
    wait_strobe(1'b0, 10, cyc, other);
    total++;
    if (cyc != 3 || bus.play !== 1'b1) begin
      bad++; $display("FAIL pre_reset_load: got %0d cycles play=%0b required 3/1", cyc, bus.play);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({bus.play, bus.song, bus.rom_addr, bus.note, bus.duration, bus.load_new_note, bus.reset_player} !== '0) begin
      bad++; $display("FAIL mid_note_reset: play=%0b song=%0d addr=%0h note=%0d dur=%0d load=%0b rp=%0b required all 0",
                      bus.play, bus.song, bus.rom_addr, bus.note, bus.duration, bus.load_new_note, bus.reset_player);
    end
    pulse(2);
    repeat (8) begin
      @(negedge clk);
      total++;
      if (bus.load_new_note !== 1'b0 || bus.play !== 1'b0 || bus.rom_addr !== 7'h00) begin
        bad++; $display("FAIL post_reset_done: load=%0b play=%0b addr=%0h required 0/0/0",
                        bus.load_new_note, bus.play, bus.rom_addr);
      end
    end
  endtask

  initial begin
    int len;
    for (int i = 0; i < 128; i++) mem[i] = {6'($urandom), 6'($urandom_range(1, 63))};
    mem[0] = {6'd10, 6'd3};
    mem[1] = {6'd12, 6'd5};
    mem[2] = {6'($urandom), 6'd0};
    len = $urandom_range(1, 31);
    mem[64 + len] = {6'($urandom), 6'd0};
    test_reset();
    play_song(0, 50, 1'b0);
    play_song(1, 30, 1'b1);
    play_song(2, 20, 1'b1);
    test_next_with_play_pause();
    test_next_during_load();
    test_next_mid_note();
    test_reset_mid_note();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
    $fatal(1);
  end
endmodule
